// File: rtl/bumpy_collision_edge.sv
`default_nettype none
// ============================================================================
//  Module      : bumpy_collision_edge
//  Description : Per-frame Bumpy/brick overlap detector and edge-band classifier
//  Revision    : 1.0 - initial release
// ============================================================================
module bumpy_collision_edge #(
    parameter int OBJECT_SIZE = 32,
    parameter int EDGE_WIDTH  = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    input  logic               smileyDrawingRequest,
    input  logic               brickDrawingRequest,
    input  logic               EndGame,
    output logic               collision,
    output logic [3:0]         HitEdgeCode,
    output logic               collisionPulse
);

    localparam logic [11:0] c_SIZE     = 12'(OBJECT_SIZE);
    localparam logic [11:0] c_EDGE     = 12'(EDGE_WIDTH);
    localparam logic [11:0] c_FAR_BAND = 12'(OBJECT_SIZE - EDGE_WIDTH);

    typedef enum logic [0:0] {
        IDLE_FRAME = 1'b0,
        HIT_FRAME  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_hitAcc;
    logic [3:0]  r_edgeAcc;
    logic        r_collision;
    logic [3:0]  r_hitEdgeCode;
    logic        r_collisionPulse;

    logic        w_hit;
    logic [11:0] w_offX;
    logic [11:0] w_offY;
    logic        w_inX;
    logic        w_inY;
    logic [3:0]  w_edge;

    assign w_hit = smileyDrawingRequest & brickDrawingRequest;

    // Sign-extend the top-left corner so a partly off-screen sprite subtracts without wrap
    assign w_offX = {1'b0, pixelX} - {topLeftX[10], topLeftX};
    assign w_offY = {1'b0, pixelY} - {topLeftY[10], topLeftY};

    assign w_inX = ~w_offX[11] && (w_offX < c_SIZE);
    assign w_inY = ~w_offY[11] && (w_offY < c_SIZE);

    always_comb begin
        w_edge = 4'b0000;
        if (w_hit && w_inX && w_inY) begin
            w_edge[0] = (w_offY >= c_FAR_BAND);
            w_edge[1] = (w_offX >= c_FAR_BAND);
            w_edge[2] = (w_offY <  c_EDGE);
            w_edge[3] = (w_offX <  c_EDGE);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state          <= IDLE_FRAME;
            r_hitAcc         <= 1'b0;
            r_edgeAcc        <= 4'b0000;
            r_collision      <= 1'b0;
            r_hitEdgeCode    <= 4'b0000;
            r_collisionPulse <= 1'b0;
        end else if (EndGame) begin
            r_state          <= IDLE_FRAME;
            r_hitAcc         <= 1'b0;
            r_edgeAcc        <= 4'b0000;
            r_collision      <= 1'b0;
            r_hitEdgeCode    <= 4'b0000;
            r_collisionPulse <= 1'b0;
        end else if (startOfFrame) begin
            // Publish the finished frame; a coincident hit seeds the new frame
            r_collision      <= r_hitAcc;
            r_hitEdgeCode    <= r_edgeAcc;
            r_hitAcc         <= w_hit;
            r_edgeAcc        <= w_edge;
            r_state          <= w_hit ? HIT_FRAME : IDLE_FRAME;
            r_collisionPulse <= w_hit;
        end else begin
            r_hitAcc         <= r_hitAcc | w_hit;
            r_edgeAcc        <= r_edgeAcc | w_edge;
            r_collisionPulse <= w_hit && (r_state == IDLE_FRAME);
            if (w_hit)
                r_state <= HIT_FRAME;
        end
    end

    assign collision      = r_collision;
    assign HitEdgeCode    = r_hitEdgeCode;
    assign collisionPulse = r_collisionPulse;

endmodule
`default_nettype wire

// File: tb/tb_bumpy_collision_edge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bumpy_collision_edge
//  Description : Directed self-checking bench for bumpy_collision_edge
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bumpy_collision_edge;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic [10:0]        pixelX;
    logic [10:0]        pixelY;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               smileyDrawingRequest;
    logic               brickDrawingRequest;
    logic               EndGame;
    logic               collision;
    logic [3:0]         HitEdgeCode;
    logic               collisionPulse;

    int n_checks = 0;
    int n_fail   = 0;

    bumpy_collision_edge #(.OBJECT_SIZE(32), .EDGE_WIDTH(4)) dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .pixelX               (pixelX),
        .pixelY               (pixelY),
        .topLeftX             (topLeftX),
        .topLeftY             (topLeftY),
        .smileyDrawingRequest (smileyDrawingRequest),
        .brickDrawingRequest  (brickDrawingRequest),
        .EndGame              (EndGame),
        .collision            (collision),
        .HitEdgeCode          (HitEdgeCode),
        .collisionPulse       (collisionPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one overlap pixel for a single cycle; returns on the following negedge
    task automatic pix(input int x, input int y);
        @(negedge clk);
        pixelX = 11'(x);
        pixelY = 11'(y);
        smileyDrawingRequest = 1'b1;
        brickDrawingRequest  = 1'b1;
        @(negedge clk);
        smileyDrawingRequest = 1'b0;
        brickDrawingRequest  = 1'b0;
    endtask

    task automatic sof();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (collision !== 1'b0 || HitEdgeCode !== 4'b0000 || collisionPulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got col=%b code=%b pulse=%b, want 0/0000/0",
                     collision, HitEdgeCode, collisionPulse);
        end
        resetN = 1'b1;
        sof();
    endtask

    task automatic test_bottom();
        pix(110, 230);
        n_checks++;
        if (collisionPulse !== 1'b1) begin
            n_fail++;
            $display("FAIL bottom_pulse_high: got %b want 1", collisionPulse);
        end
        n_checks++;
        if (collision !== 1'b0) begin
            n_fail++;
            $display("FAIL bottom_not_yet_published: got %b want 0", collision);
        end
        @(negedge clk);
        n_checks++;
        if (collisionPulse !== 1'b0) begin
            n_fail++;
            $display("FAIL bottom_pulse_single: got %b want 0", collisionPulse);
        end
        sof();
        n_checks++;
        if (collision !== 1'b1 || HitEdgeCode !== 4'b0001) begin
            n_fail++;
            $display("FAIL bottom_publish: got col=%b code=%b want 1/0001", collision, HitEdgeCode);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (collision !== 1'b1 || HitEdgeCode !== 4'b0001) begin
            n_fail++;
            $display("FAIL bottom_hold: got col=%b code=%b want 1/0001", collision, HitEdgeCode);
        end
    endtask

    task automatic test_corner();
        pix(101, 231);
        n_checks++;
        if (collisionPulse !== 1'b1) begin
            n_fail++;
            $display("FAIL corner_pulse_first: got %b want 1", collisionPulse);
        end
        repeat (3) @(negedge clk);
        pix(131, 215);
        n_checks++;
        if (collisionPulse !== 1'b0) begin
            n_fail++;
            $display("FAIL corner_pulse_second: got %b want 0", collisionPulse);
        end
        n_checks++;
        if (collision !== 1'b1 || HitEdgeCode !== 4'b0001) begin
            n_fail++;
            $display("FAIL corner_prev_held: got col=%b code=%b want 1/0001", collision, HitEdgeCode);
        end
        sof();
        n_checks++;
        if (collision !== 1'b1 || HitEdgeCode !== 4'b1011) begin
            n_fail++;
            $display("FAIL corner_publish: got col=%b code=%b want 1/1011", collision, HitEdgeCode);
        end
    endtask

    task automatic test_interior_nohit();
        pix(116, 216);
        sof();
        n_checks++;
        if (collision !== 1'b1 || HitEdgeCode !== 4'b0000) begin
            n_fail++;
            $display("FAIL interior_publish: got col=%b code=%b want 1/0000", collision, HitEdgeCode);
        end
        repeat (4) @(negedge clk);
        sof();
        n_checks++;
        if (collision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
            n_fail++;
            $display("FAIL nohit_publish: got col=%b code=%b want 0/0000", collision, HitEdgeCode);
        end
        pix(116, 216);
        sof();
        sof();
        n_checks++;
        if (collision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
            n_fail++;
            $display("FAIL back_to_back_sof: got col=%b code=%b want 0/0000", collision, HitEdgeCode);
        end
    endtask

    task automatic test_same_cycle();
        pix(110, 230);
        @(negedge clk);
        startOfFrame = 1'b1;
        pixelX = 11'd110;
        pixelY = 11'd201;
        smileyDrawingRequest = 1'b1;
        brickDrawingRequest  = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        smileyDrawingRequest = 1'b0;
        brickDrawingRequest  = 1'b0;
        n_checks++;
        if (collision !== 1'b1 || HitEdgeCode !== 4'b0001) begin
            n_fail++;
            $display("FAIL same_cycle_old_frame: got col=%b code=%b want 1/0001", collision, HitEdgeCode);
        end
        n_checks++;
        if (collisionPulse !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_pulse: got %b want 1", collisionPulse);
        end
        repeat (3) @(negedge clk);
        sof();
        n_checks++;
        if (collision !== 1'b1 || HitEdgeCode !== 4'b0100) begin
            n_fail++;
            $display("FAIL same_cycle_new_frame: got col=%b code=%b want 1/0100", collision, HitEdgeCode);
        end
    endtask

    task automatic test_endgame();
        @(negedge clk);
        EndGame = 1'b1;
        @(negedge clk);
        n_checks++;
        if (collision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
            n_fail++;
            $display("FAIL endgame_clear: got col=%b code=%b want 0/0000", collision, HitEdgeCode);
        end
        pix(110, 230);
        n_checks++;
        if (collisionPulse !== 1'b0) begin
            n_fail++;
            $display("FAIL endgame_pulse: got %b want 0", collisionPulse);
        end
        sof();
        n_checks++;
        if (collision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
            n_fail++;
            $display("FAIL endgame_no_publish: got col=%b code=%b want 0/0000", collision, HitEdgeCode);
        end
        EndGame = 1'b0;
        sof();
        n_checks++;
        if (collision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
            n_fail++;
            $display("FAIL endgame_acc_discarded: got col=%b code=%b want 0/0000", collision, HitEdgeCode);
        end
    endtask

    task automatic test_async_reset();
        pix(101, 231);
        sof();
        pix(131, 215);
        #2 resetN = 1'b0;
        #1;
        n_checks++;
        if (collision !== 1'b0 || HitEdgeCode !== 4'b0000 || collisionPulse !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got col=%b code=%b pulse=%b want 0/0000/0",
                     collision, HitEdgeCode, collisionPulse);
        end
        @(negedge clk);
        resetN = 1'b1;
        sof();
        n_checks++;
        if (collision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_discard: got col=%b code=%b want 0/0000", collision, HitEdgeCode);
        end
    endtask

    task automatic test_negative_and_range();
        topLeftX = -11'sd10;
        pix(0, 216);
        pix(19, 216);
        sof();
        n_checks++;
        if (collision !== 1'b1 || HitEdgeCode !== 4'b0010) begin
            n_fail++;
            $display("FAIL negative_topleft: got col=%b code=%b want 1/0010", collision, HitEdgeCode);
        end
        topLeftX = 11'sd100;
        pix(50, 216);
        pix(140, 201);
        sof();
        n_checks++;
        if (collision !== 1'b1 || HitEdgeCode !== 4'b0000) begin
            n_fail++;
            $display("FAIL out_of_range: got col=%b code=%b want 1/0000", collision, HitEdgeCode);
        end
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        pixelX = 11'd0;
        pixelY = 11'd0;
        topLeftX = 11'sd100;
        topLeftY = 11'sd200;
        smileyDrawingRequest = 1'b0;
        brickDrawingRequest  = 1'b0;
        EndGame = 1'b0;

        test_reset();
        test_bottom();
        test_corner();
        test_interior_nohit();
        test_same_cycle();
        test_endgame();
        test_async_reset();
        test_negative_and_range();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
